// File: rtl/adc_sample_buffer.sv
// Sample buffer behind the ADC SPI controller: filters samples by channel mask,
// tags them with channel and timestamp, and queues them in a synchronous FIFO.
module adc_sample_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OVF_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [11:0]         sample,
    input  logic [3:0]          sample_channel,
    input  logic [15:0]         chan_enable,
    input  logic                clear,
    input  logic                rd_en,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic [OVF_W-1:0]    ovf_count
);

    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX  = {OVF_W{1'b1}};

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       ts_q, ts_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [OVF_W-1:0]  ovf_count_q, ovf_count_d;
    logic              wr_req_s, rd_ok_s, wr_ok_s, drop_s;
    logic [31:0]       word_s;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        wr_req_s    = sample_valid & chan_enable[sample_channel];
        rd_ok_s     = rd_en & (count_q != {(ADDR_W+1){1'b0}});
        wr_ok_s     = wr_req_s & (~full_q | rd_ok_s);
        drop_s      = wr_req_s & ~wr_ok_s;
        word_s      = {sample_channel, sample, ts_q};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ts_d        = ts_q + 16'd1;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        ovf_count_d = ovf_count_q;
        if (clear) begin
            wr_ptr_d    = {ADDR_W{1'b0}};
            rd_ptr_d    = {ADDR_W{1'b0}};
            count_d     = {(ADDR_W+1){1'b0}};
            ts_d        = 16'd0;
            rd_data_d   = 32'd0;
            overflow_d  = 1'b0;
            ovf_count_d = {OVF_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
                if (ovf_count_q != OVF_MAX) begin
                    ovf_count_d = ovf_count_q + OVF_W'(1);
                end else begin
                    ovf_count_d = ovf_count_q;
                end
            end else begin
                overflow_d = overflow_q;
            end
        end
        empty_d = (count_d == {(ADDR_W+1){1'b0}});
        full_d  = (count_d == FULL_CNT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {(ADDR_W+1){1'b0}};
            ts_q        <= 16'd0;
            rd_data_q   <= 32'd0;
            rd_valid_q  <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            ovf_count_q <= {OVF_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ts_q        <= ts_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (reset && !clear && wr_ok_s) begin
            mem_q[wr_ptr_q] <= word_s;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
- Downstream consumer of the ADC SPI controller's 12-bit samples.
- Filters samples by a per-channel enable mask and tags each with its channel and a 16-bit timestamp.
- Stores tagged words in a synchronous FIFO that the bus interface drains with single-word reads.
- Counts samples dropped while the FIFO is full.

Parameters:
DEPTH, 16, FIFO depth in words; power of two, at least 2
ADDR_W, 4, log2(DEPTH)
OVF_W, 8, width of the dropped-sample counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  active-low synchronous reset
sample_valid  input  1  one-cycle strobe: sample/sample_channel valid
sample  input  12  conversion result from ADC controller
sample_channel  input  4  channel the sample belongs to
chan_enable  input  16  bit n=1 accepts samples from channel n
clear  input  1  synchronous flush of FIFO, counters and timestamp
rd_en  input  1  read request from bus side
rd_data  output  32  {channel[31:28], sample[27:16], timestamp[15:0]}
rd_valid  output  1  rd_data valid this cycle (one-cycle pulse)
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds DEPTH words
count  output  ADDR_W+1  words currently stored, 0..DEPTH
overflow  output  1  sticky: at least one sample dropped
ovf_count  output  OVF_W  dropped samples, saturating

Behaviour:
- Reset (reset=0 at a clock edge) and clear=1 have identical effect on the next cycle:
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0.
  - overflow=0, ovf_count=0, timestamp=0.
  - rd_data=0, rd_valid=0.
- Reset has priority over clear; clear has priority over any same-cycle write or read. Both are ignored ops, not queued.
- Timestamp: 16-bit free-running counter.
  - +1 every cycle, wraps 0xFFFF->0x0000.
  - A write captures the timestamp value present in the strobe cycle.
- Write qualification: wr_req = sample_valid & chan_enable[sample_channel].
  - A disabled-channel sample is discarded silently: no FIFO change, no overflow count.
- Accept rule: a write is accepted if wr_req and (count<DEPTH, or rd_en with count>0 in the same cycle).
  - A full FIFO therefore accepts a write when a read happens in the same cycle.
  - Accepted write: mem[wr_ptr] <= {sample_channel, sample, timestamp}; wr_ptr+1 mod DEPTH.
- Drop rule: wr_req not accepted (full, no concurrent read) triggers all of the following:
  - the word is discarded;
  - overflow <= 1;
  - ovf_count increments, saturating at 2^OVF_W-1.
- Read: rd_en with count>0 transfers the word.
  - rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next edge, so latency is 1 cycle.
  - rd_ptr+1 mod DEPTH.
  - rd_en with count=0 is ignored: rd_valid=0, rd_data holds its previous value.
- rd_data holds its value until the next successful read; rd_valid is high for exactly one cycle per read.
- count:
  - +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - Never exceeds DEPTH, never below 0.
- empty=(count==0) and full=(count==DEPTH), both registered and consistent with count in the same cycle.
- Pointers wrap naturally at DEPTH; a wrapped FIFO returns words in strict arrival order.
- Back-to-back strobes every cycle and back-to-back rd_en every cycle are both supported at full rate.

Test Plan:
- Reset then idle 5 cycles -> empty=1, count=0, rd_valid=0, rd_data=0, overflow=0, ovf_count=0.
- chan_enable=0xFFFF; strobe ch=3 sample=0xABC at timestamp 0x0007; rd_en next cycle -> one cycle later rd_valid=1, rd_data=0x3ABC0007, empty=1.
- chan_enable=0x0001; strobes on ch=1 then ch=0 sample=0x123 -> count=1; the read returns channel 0, sample 0x123; ovf_count=0.
- Write 16 words (full=1), then 3 more strobes without reads -> count=16, overflow=1, ovf_count=3; the 16 reads return the first 16 samples in order.
- Full FIFO, strobe and rd_en in the same cycle -> write accepted, count stays 16, ovf_count unchanged; then clear=1 with rd_en=1 -> next cycle count=0, empty=1, overflow=0, timestamp=0, rd_valid=0.
- Wrap test: 40 writes interleaved with reads (count never above 4) -> all 40 words read in order; ovf_count saturates at 255 after 300 drops into a full FIFO.
